rv32i_core: RTL and testbench

- Single-issue, in-order RV32I integer core with a 3-stage pipeline: IF, EX, WB.
- Connects to two external synchronous SRAMs: an instruction SRAM and a data SRAM.
- Both SRAMs register the address and enables on the clock edge. Read data is valid during the following cycle.
- Memory is always ready; there is no backpressure.

---
 rtl/rv32i_pkg.sv | 67 ++++++
 rtl/rv32i_regfile.sv | 29 ++
 rtl/rv32i_core.sv | 230 +++++++++++++++++++++++
 tb/tb_rv32i_core.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
// rtl/rv32i_pkg.sv - shared opcode/funct3 constants, ALU op enum and ALU helper for rv32i_core
package rv32i_pkg;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } alu_op_e;

  function automatic logic [31:0] alu_calc(input alu_op_e op, input logic [31:0] a,
                                           input logic [31:0] b);
    logic [31:0] r;
    case (op)
      ALU_ADD:  r = a + b;
      ALU_SUB:  r = a - b;
      ALU_SLL:  r = a << b[4:0];
      ALU_SLT:  r = {31'b0, ($signed(a) < $signed(b))};
      ALU_SLTU: r = {31'b0, (a < b)};
      ALU_XOR:  r = a ^ b;
      ALU_SRL:  r = a >> b[4:0];
      ALU_SRA:  r = $unsigned($signed(a) >>> b[4:0]);
      ALU_OR:   r = a | b;
      ALU_AND:  r = a & b;
      default:  r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/rv32i_regfile.sv
// rtl/rv32i_regfile.sv - 31x32 register file, x0 hardwired to zero, 2 async reads, 1 sync write
module rv32i_regfile
  import rv32i_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic [4:0]  ra1_i,
  input  logic [4:0]  ra2_i,
  output logic [31:0] rd1_o,
  output logic [31:0] rd2_o,
  input  logic        we_i,
  input  logic [4:0]  wa_i,
  input  logic [31:0] wd_i
);

  logic [31:0] regs_q [1:31];

  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 1; i < 32; i++) regs_q[i] <= '0;
    end else if (we_i && (wa_i != 5'd0)) begin
      regs_q[wa_i] <= wd_i;
    end
  end

  assign rd1_o = (ra1_i == 5'd0) ? '0 : regs_q[ra1_i];
  assign rd2_o = (ra2_i == 5'd0) ? '0 : regs_q[ra2_i];

endmodule

// File: rtl/rv32i_core.sv
// rtl/rv32i_core.sv - 3-stage (IF/EX/WB) RV32I core; CORE_SUBWORD_LSU_EN adds LB/LH/LBU/LHU/SB/SH
module rv32i_core #(
  parameter logic [31:0] RESET_PC = rv32i_pkg::RESET_PC
) (
  input  logic        clk,
  input  logic        rstn,
  output logic [15:0] ins_a,
  output logic        ins_e,
  input  logic [31:0] ins,
  output logic [15:0] dat_a,
  output logic [3:0]  dat_we,
  output logic [31:0] dat_wd,
  output logic [3:0]  dat_re,
  input  logic [31:0] dat_rd
);
  import rv32i_pkg::*;

  logic [31:0] pc_q, pc_d, ex_pc_q;
  logic        ex_vld_q;
  logic        wb_vld_q, wb_we_q, wb_ld_q;
  logic [4:0]  wb_rd_q;
  logic [31:0] wb_alu_q;
`ifdef CORE_SUBWORD_LSU_EN
  logic [2:0]  wb_f3_q;
  logic [1:0]  wb_ea_q;
`endif

  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  f3;
  logic [31:0] imm_i, imm_b, imm_u, imm_j;
  logic [15:0] imm_s, ea;
  logic [31:0] rf_rd1, rf_rd2, rs1_val, rs2_val;
  logic [31:0] ld_data, wb_res;
  logic        wb_fwd;

  alu_op_e     alu_op;
  logic [31:0] alu_b, alu_res;
  logic        br_taken;

  logic        rd_we, ld_ok, st_ok, jump, redirect, mem_act;
  logic [31:0] ex_res, target, st_data;
  logic [3:0]  be;

  assign opcode = ins[6:0];
  assign rd     = ins[11:7];
  assign f3     = ins[14:12];
  assign rs1    = ins[19:15];
  assign rs2    = ins[24:20];
  assign imm_i  = {{20{ins[31]}}, ins[31:20]};
  assign imm_s  = {{4{ins[31]}}, ins[31:25], ins[11:7]};
  assign imm_b  = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
  assign imm_u  = {ins[31:12], 12'b0};
  assign imm_j  = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};

  rv32i_regfile u_rf (
    .clk   (clk),
    .rstn  (rstn),
    .ra1_i (rs1),
    .ra2_i (rs2),
    .rd1_o (rf_rd1),
    .rd2_o (rf_rd2),
    .we_i  (wb_vld_q && wb_we_q),
    .wa_i  (wb_rd_q),
    .wd_i  (wb_res)
  );

  // Load lane extraction uses the WB-registered address and funct3.
`ifdef CORE_SUBWORD_LSU_EN
  logic [31:0] lane_b, lane_h;
  assign lane_b = dat_rd >> {wb_ea_q, 3'b000};
  assign lane_h = dat_rd >> {wb_ea_q[1], 4'b0000};
  always_comb begin
    ld_data = dat_rd;
    case (wb_f3_q)
      F3_LB:   ld_data = {{24{lane_b[7]}}, lane_b[7:0]};
      F3_LBU:  ld_data = {24'b0, lane_b[7:0]};
      F3_LH:   ld_data = {{16{lane_h[15]}}, lane_h[15:0]};
      F3_LHU:  ld_data = {16'b0, lane_h[15:0]};
      default: ld_data = dat_rd;
    endcase
  end
`else
  assign ld_data = dat_rd;
`endif

  assign wb_res  = wb_ld_q ? ld_data : wb_alu_q;
  assign wb_fwd  = wb_vld_q && wb_we_q && (wb_rd_q != 5'd0);
  assign rs1_val = (wb_fwd && (wb_rd_q == rs1)) ? wb_res : rf_rd1;
  assign rs2_val = (wb_fwd && (wb_rd_q == rs2)) ? wb_res : rf_rd2;

  always_comb begin
    alu_op = ALU_ADD;
    case (f3)
      F3_ADD:  alu_op = ((opcode == OPC_OP) && ins[30]) ? ALU_SUB : ALU_ADD;
      F3_SLL:  alu_op = ALU_SLL;
      F3_SLT:  alu_op = ALU_SLT;
      F3_SLTU: alu_op = ALU_SLTU;
      F3_XOR:  alu_op = ALU_XOR;
      F3_SR:   alu_op = ins[30] ? ALU_SRA : ALU_SRL;
      F3_OR:   alu_op = ALU_OR;
      F3_AND:  alu_op = ALU_AND;
      default: alu_op = ALU_ADD;
    endcase
  end

  assign alu_b   = (opcode == OPC_OP) ? rs2_val : imm_i;
  assign alu_res = alu_calc(alu_op, rs1_val, alu_b);
  assign ea      = rs1_val[15:0] + ((opcode == OPC_STORE) ? imm_s : imm_i[15:0]);

  always_comb begin
    br_taken = 1'b0;
    case (f3)
      F3_BEQ:  br_taken = (rs1_val == rs2_val);
      F3_BNE:  br_taken = (rs1_val != rs2_val);
      F3_BLT:  br_taken = ($signed(rs1_val) < $signed(rs2_val));
      F3_BGE:  br_taken = ($signed(rs1_val) >= $signed(rs2_val));
      F3_BLTU: br_taken = (rs1_val < rs2_val);
      F3_BGEU: br_taken = (rs1_val >= rs2_val);
      default: br_taken = 1'b0;
    endcase
  end

  // Anything not decoded below (FENCE, SYSTEM, unknown) falls through as a NOP.
  always_comb begin
    rd_we   = 1'b0;
    ld_ok   = 1'b0;
    st_ok   = 1'b0;
    jump    = 1'b0;
    ex_res  = alu_res;
    target  = '0;
    be      = 4'b0000;
    st_data = '0;
    case (opcode)
      OPC_LUI: begin
        rd_we  = 1'b1;
        ex_res = imm_u;
      end
      OPC_AUIPC: begin
        rd_we  = 1'b1;
        ex_res = ex_pc_q + imm_u;
      end
      OPC_JAL: begin
        rd_we  = 1'b1;
        ex_res = ex_pc_q + 32'd4;
        jump   = 1'b1;
        target = ex_pc_q + imm_j;
      end
      OPC_JALR: begin
        rd_we  = 1'b1;
        ex_res = ex_pc_q + 32'd4;
        jump   = 1'b1;
        target = (rs1_val + imm_i) & 32'hFFFF_FFFE;
      end
      OPC_BRANCH: begin
        jump   = br_taken;
        target = ex_pc_q + imm_b;
      end
      OPC_LOAD: begin
        case (f3)
          F3_LW: begin ld_ok = 1'b1; be = 4'b1111; end
`ifdef CORE_SUBWORD_LSU_EN
          F3_LB, F3_LBU: begin ld_ok = 1'b1; be = 4'b0001 << ea[1:0]; end
          F3_LH, F3_LHU: begin ld_ok = 1'b1; be = 4'b0011 << {ea[1], 1'b0}; end
`endif
          default: ld_ok = 1'b0;
        endcase
        rd_we = ld_ok;
      end
      OPC_STORE: begin
        case (f3)
          F3_SW: begin st_ok = 1'b1; be = 4'b1111; st_data = rs2_val; end
`ifdef CORE_SUBWORD_LSU_EN
          F3_SB: begin st_ok = 1'b1; be = 4'b0001 << ea[1:0]; st_data = {4{rs2_val[7:0]}}; end
          F3_SH: begin st_ok = 1'b1; be = 4'b0011 << {ea[1], 1'b0}; st_data = {2{rs2_val[15:0]}}; end
`endif
          default: st_ok = 1'b0;
        endcase
      end
      OPC_OP_IMM, OPC_OP: rd_we = 1'b1;
      default: rd_we = 1'b0;
    endcase
  end

  assign redirect = ex_vld_q && jump;
  assign pc_d     = redirect ? target : pc_q + 32'd4;
  assign mem_act  = rstn && ex_vld_q && (ld_ok || st_ok);

  assign ins_a  = pc_q[15:0];
  assign ins_e  = rstn;
  assign dat_a  = mem_act ? ea : 16'h0000;
  assign dat_we = (mem_act && st_ok) ? be : 4'b0000;
  assign dat_re = (mem_act && ld_ok) ? be : 4'b0000;
  assign dat_wd = (mem_act && st_ok) ? st_data : 32'h0;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      pc_q     <= RESET_PC;
      ex_pc_q  <= RESET_PC;
      ex_vld_q <= 1'b0;
      wb_vld_q <= 1'b0;
      wb_we_q  <= 1'b0;
      wb_ld_q  <= 1'b0;
      wb_rd_q  <= 5'd0;
      wb_alu_q <= '0;
    end else begin
      pc_q     <= pc_d;
      ex_pc_q  <= pc_q;
      ex_vld_q <= !redirect;
      wb_vld_q <= ex_vld_q;
      wb_we_q  <= rd_we;
      wb_ld_q  <= ld_ok;
      wb_rd_q  <= rd;
      wb_alu_q <= ex_res;
    end
  end

`ifdef CORE_SUBWORD_LSU_EN
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wb_f3_q <= 3'b000;
      wb_ea_q <= 2'b00;
    end else begin
      wb_f3_q <= f3;
      wb_ea_q <= ea[1:0];
    end
  end
`endif

endmodule

// File: tb/tb_rv32i_core.sv
// tb/tb_rv32i_core.sv - directed bench for rv32i_core with behavioural instruction/data SRAMs
module tb_rv32i_core;

  logic        clk = 1'b0;
  logic        rstn;
  logic [15:0] ins_a, dat_a;
  logic        ins_e;
  logic [31:0] ins, dat_wd, dat_rd;
  logic [3:0]  dat_we, dat_re;

  logic [31:0] imem [0:16383];
  logic [31:0] dmem [0:16383];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 clk = ~clk;

  rv32i_core #(.RESET_PC(32'h0000_0000)) dut (
    .clk    (clk),
    .rstn   (rstn),
    .ins_a  (ins_a),
    .ins_e  (ins_e),
    .ins    (ins),
    .dat_a  (dat_a),
    .dat_we (dat_we),
    .dat_wd (dat_wd),
    .dat_re (dat_re),
    .dat_rd (dat_rd)
  );

  always @(posedge clk) begin
    if (ins_e) ins <= imem[ins_a[15:2]];
    for (int b = 0; b < 4; b++)
      if (dat_we[b]) dmem[dat_a[15:2]][8*b +: 8] <= dat_wd[8*b +: 8];
    if (|dat_re) dat_rd <= dmem[dat_a[15:2]];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
  endtask

  task automatic goto(input int n);
    while (cyc < n) step();
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) begin
      imem[i] = 32'h0000_0013;
      dmem[i] = 32'h0;
    end
    imem['h00 >> 2] = 32'h0050_0093;  // addi x1,x0,5
    imem['h04 >> 2] = 32'h0030_8113;  // addi x2,x1,3
    imem['h08 >> 2] = 32'h0070_0013;  // addi x0,x0,7
    imem['h0C >> 2] = 32'h0020_2823;  // sw   x2,0x10(x0)
    imem['h10 >> 2] = 32'h0100_2183;  // lw   x3,0x10(x0)
    imem['h14 >> 2] = 32'h0031_8233;  // add  x4,x3,x3
    imem['h18 >> 2] = 32'h0010_9463;  // bne  x1,x1,+8
    imem['h1C >> 2] = 32'h0010_0413;  // addi x8,x0,1
    imem['h20 >> 2] = 32'h0010_8463;  // beq  x1,x1,+8
    imem['h24 >> 2] = 32'h0090_0493;  // addi x9,x0,9 (squashed)
    imem['h28 >> 2] = 32'h00A0_0513;  // addi x10,x0,10
    imem['h40 >> 2] = 32'h1000_00EF;  // jal  x1,+0x100
    imem['h44 >> 2] = 32'h00B0_0593;  // addi x11,x0,11
    imem['h50 >> 2] = 32'h1234_52B7;  // lui  x5,0x12345
    imem['h54 >> 2] = 32'h0000_1317;  // auipc x6,1
    imem['h58 >> 2] = 32'h4042_D393;  // srai x7,x5,4
    imem['h5C >> 2] = 32'h0070_2A23;  // sw   x7,0x14(x0)
    imem['h60 >> 2] = 32'h0000_006F;  // jal  x0,0
    imem['h140 >> 2] = 32'h0010_8067; // jalr x0,1(x1)
    imem['h144 >> 2] = 32'h00C0_0613; // addi x12,x0,12 (squashed)

    rstn = 1'b0;
    @(negedge clk);
    chk("rst1_ins_e", {31'b0, ins_e}, 32'h0);
    chk("rst1_dat_we", {28'b0, dat_we}, 32'h0);
    chk("rst1_dat_re", {28'b0, dat_re}, 32'h0);
    @(negedge clk);
    chk("rst2_ins_e", {31'b0, ins_e}, 32'h0);
    chk("rst2_dat_we", {28'b0, dat_we}, 32'h0);
    chk("rst2_dat_re", {28'b0, dat_re}, 32'h0);
    chk("rst2_dat_a", {16'b0, dat_a}, 32'h0);
    chk("rst2_dat_wd", dat_wd, 32'h0);
    rstn = 1'b1;
    #1;
    chk("n0_ins_a", {16'b0, ins_a}, 32'h0000);
    chk("n0_ins_e", {31'b0, ins_e}, 32'h1);
    step();
    chk("n1_ins_a", {16'b0, ins_a}, 32'h0004);
    step();
    chk("n2_ins_a", {16'b0, ins_a}, 32'h0008);

    goto(4);
    chk("sw_dat_a", {16'b0, dat_a}, 32'h0010);
    chk("sw_dat_we", {28'b0, dat_we}, 32'hF);
    chk("sw_dat_wd", dat_wd, 32'h8);
    chk("sw_dat_re", {28'b0, dat_re}, 32'h0);
    step();
    chk("lw_dat_re", {28'b0, dat_re}, 32'hF);
    chk("lw_dat_a", {16'b0, dat_a}, 32'h0010);
    chk("lw_dat_we", {28'b0, dat_we}, 32'h0);

    goto(8);
    chk("bne_fallthru_ins_a", {16'b0, ins_a}, 32'h0020);
    step();
    chk("beq_ins_a_24", {16'b0, ins_a}, 32'h0024);
    step();
    chk("beq_ins_a_28", {16'b0, ins_a}, 32'h0028);

    goto(18);
    chk("jal_ins_a", {16'b0, ins_a}, 32'h0140);
    goto(20);
    chk("jalr_ins_a", {16'b0, ins_a}, 32'h0044);

    goto(27);
    chk("sw2_dat_a", {16'b0, dat_a}, 32'h0014);
    chk("sw2_dat_we", {28'b0, dat_we}, 32'hF);
    chk("sw2_dat_wd", dat_wd, 32'h0123_4500);

    goto(34);
    chk("x1", dut.u_rf.regs_q[1], 32'h0000_0044);
    chk("x2", dut.u_rf.regs_q[2], 32'h0000_0008);
    chk("x3", dut.u_rf.regs_q[3], 32'h0000_0008);
    chk("x4", dut.u_rf.regs_q[4], 32'h0000_0010);
    chk("x5", dut.u_rf.regs_q[5], 32'h1234_5000);
    chk("x6", dut.u_rf.regs_q[6], 32'h0000_1054);
    chk("x7", dut.u_rf.regs_q[7], 32'h0123_4500);
    chk("x8", dut.u_rf.regs_q[8], 32'h0000_0001);
    chk("x9_squashed", dut.u_rf.regs_q[9], 32'h0000_0000);
    chk("x10", dut.u_rf.regs_q[10], 32'h0000_000A);
    chk("x11", dut.u_rf.regs_q[11], 32'h0000_000B);
    chk("x12_squashed", dut.u_rf.regs_q[12], 32'h0000_0000);
    chk("dmem_0x14", dmem['h14 >> 2], 32'h0123_4500);

    rstn = 1'b0;
    #1;
    chk("midrst_ins_e", {31'b0, ins_e}, 32'h0);
    chk("midrst_dat_we", {28'b0, dat_we}, 32'h0);
    chk("midrst_dat_re", {28'b0, dat_re}, 32'h0);
    step();
    chk("midrst_ins_a", {16'b0, ins_a}, 32'h0000);
    chk("midrst_x5", dut.u_rf.regs_q[5], 32'h0);
    rstn = 1'b1;
    #1;
    chk("midrst_release_ins_e", {31'b0, ins_e}, 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
